// File: rtl/inst_fetch_if_id.sv
// inst_fetch_if_id: SRAM instruction fetch FSM with stall request and IF/ID pipeline register
module inst_fetch_if_id #(
   parameter int WAIT_CYCLES = 2,
   parameter int SRAM_AW     = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        pc_i,
   input  logic               ce_i,
   input  logic [5:0]         stall_i,
   input  logic               flush_i,
   output logic [SRAM_AW-1:0] inst_sram_addr_o,
   output logic               inst_sram_ce_n_o,
   output logic               inst_sram_oe_n_o,
   output logic               inst_sram_we_n_o,
   input  logic [31:0]        inst_sram_rdata_i,
   output logic               stallreq_o,
   output logic [31:0]        id_pc_o,
   output logic [31:0]        id_inst_o
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [3:0] LAST   = 4'(WAIT_CYCLES - 1);

   logic [1:0]  r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_inst_buf;
   logic        w_done;
   logic        w_last;
   logic        w_unused;

   assign w_done           = r_state == S_DONE;
   assign w_last           = r_cnt == LAST;
   assign inst_sram_we_n_o = 1'b1;
   assign stallreq_o       = ce_i & ~w_done;
   assign w_unused         = ^{stall_i[5:3], stall_i[0], pc_i[31:SRAM_AW+2], pc_i[1:0]};

   // fetch FSM: launch SRAM read, count wait cycles, buffer the word until ID accepts it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= S_IDLE;
         r_cnt            <= '0;
         r_inst_buf       <= '0;
         inst_sram_addr_o <= '0;
         inst_sram_ce_n_o <= 1'b1;
         inst_sram_oe_n_o <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ce_i && !flush_i) begin
                  inst_sram_addr_o <= pc_i[SRAM_AW+1:2];
                  inst_sram_ce_n_o <= 1'b0;
                  inst_sram_oe_n_o <= 1'b0;
                  r_cnt            <= '0;
                  r_state          <= S_READ;
               end
            end
            S_READ: begin
               if (flush_i) begin
                  inst_sram_ce_n_o <= 1'b1;
                  inst_sram_oe_n_o <= 1'b1;
                  r_cnt            <= '0;
                  r_state          <= S_IDLE;
               end else if (w_last) begin
                  r_inst_buf       <= inst_sram_rdata_i;
                  inst_sram_ce_n_o <= 1'b1;
                  inst_sram_oe_n_o <= 1'b1;
                  r_state          <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            S_DONE: begin
               if (flush_i) begin
                  r_inst_buf <= '0;
                  r_state    <= S_IDLE;
               end else if (!stall_i[1]) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // IF/ID register: flush/reset clear, bubble when IF stops alone or nothing is ready, capture on DONE
   always_ff @(posedge clk) begin
      if (rst || flush_i || (stall_i[1] && !stall_i[2])) begin
         id_pc_o   <= '0;
         id_inst_o <= '0;
      end else if (!stall_i[1]) begin
         id_pc_o   <= w_done ? pc_i : 32'd0;
         id_inst_o <= w_done ? r_inst_buf : 32'd0;
      end
   end
endmodule

// File: tb/tb_inst_fetch_if_id.sv
// tb_inst_fetch_if_id: directed stimulus with a scoreboard-checked IF/ID output stream
module tb_inst_fetch_if_id;
   localparam int W1 = 2;

   logic        clk = 1'b0;
   logic        rst, ce_i, flush_i;
   logic [31:0] pc_i;
   logic [5:0]  stall_i;

   logic [19:0] addr1, addr2;
   logic        ce_n1, oe_n1, we_n1, stallreq1;
   logic        ce_n2, oe_n2, we_n2, stallreq2;
   logic [31:0] rdata1, rdata2, id_pc1, id_inst1, id_pc2, id_inst2;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] sb[$];
   logic [63:0] exp_e;
   logic        cap = 1'b0;
   logic [31:0] prev_pc = '0;
   logic [31:0] prev_inst = '0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [19:0] a);
      case (a)
         20'h00000: mem = 32'h3C011234;
         20'h00001: mem = 32'h24210001;
         20'h00002: mem = 32'h8C220000;
         20'h00003: mem = 32'h00851020;
         20'h00004: mem = 32'hAAAA5555;
         20'h00005: mem = 32'h12345678;
         20'h00060: mem = 32'h3C1FBFC0;
         default:   mem = 32'hBAD0BAD0;
      endcase
   endfunction

   assign rdata1 = oe_n1 ? 32'hFFFFFFFF : mem(addr1);
   assign rdata2 = oe_n2 ? 32'hFFFFFFFF : mem(addr2);

   inst_fetch_if_id #(.WAIT_CYCLES(W1), .SRAM_AW(20)) dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .stall_i(stall_i), .flush_i(flush_i),
      .inst_sram_addr_o(addr1), .inst_sram_ce_n_o(ce_n1), .inst_sram_oe_n_o(oe_n1),
      .inst_sram_we_n_o(we_n1), .inst_sram_rdata_i(rdata1), .stallreq_o(stallreq1),
      .id_pc_o(id_pc1), .id_inst_o(id_inst1)
   );

   inst_fetch_if_id #(.WAIT_CYCLES(1), .SRAM_AW(20)) dut_w1 (
      .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .stall_i(stall_i), .flush_i(flush_i),
      .inst_sram_addr_o(addr2), .inst_sram_ce_n_o(ce_n2), .inst_sram_oe_n_o(oe_n2),
      .inst_sram_we_n_o(we_n2), .inst_sram_rdata_i(rdata2), .stallreq_o(stallreq2),
      .id_pc_o(id_pc2), .id_inst_o(id_inst2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // one fetch from IDLE; sv is the stall vector during READ/DONE, held h extra cycles in DONE
   task automatic fetch(input logic [31:0] pc, input logic [31:0] d, input logic [5:0] sv, input int h);
      pc_i    = pc;
      ce_i    = 1'b1;
      stall_i = sv;
      sb.push_back({pc, d});
      #1;
      chk("stallreq_idle", 32'(stallreq1), 32'd1);
      repeat (W1) begin
         tick;
         chk("ce_n_read", 32'(ce_n1), 32'd0);
         chk("oe_n_read", 32'(oe_n1), 32'd0);
         chk("addr_read", 32'(addr1), 32'(pc[21:2]));
         chk("stallreq_read", 32'(stallreq1), 32'd1);
         chk("id_inst_read", id_inst1, sv[2] ? prev_inst : 32'd0);
      end
      tick;
      chk("ce_n_done", 32'(ce_n1), 32'd1);
      chk("oe_n_done", 32'(oe_n1), 32'd1);
      chk("stallreq_done", 32'(stallreq1), 32'd0);
      repeat (h) begin
         tick;
         chk("stallreq_held", 32'(stallreq1), 32'd0);
         chk("id_inst_stall", id_inst1, sv[2] ? prev_inst : 32'd0);
         chk("id_pc_stall", id_pc1, sv[2] ? prev_pc : 32'd0);
      end
      stall_i = '0;
      tick;
      prev_pc   = pc;
      prev_inst = d;
   endtask

   // monitor: a capture edge is one where ID is free and the fetch stage reports no stall
   always @(negedge clk) begin
      if (cap) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL capture: got pc %h inst %h expected no delivery", id_pc1, id_inst1);
         end else begin
            exp_e = sb.pop_front();
            chk("sb_id_pc", id_pc1, exp_e[63:32]);
            chk("sb_id_inst", id_inst1, exp_e[31:0]);
         end
      end
      cap = !rst && !flush_i && ce_i && !stallreq1 && !stall_i[1];
   end

   initial begin
      rst = 1'b1; ce_i = 1'b0; flush_i = 1'b0; pc_i = '0; stall_i = '0;
      tick;
      tick;
      chk("rst_addr", 32'(addr1), 32'd0);
      chk("rst_ce_n", 32'(ce_n1), 32'd1);
      chk("rst_oe_n", 32'(oe_n1), 32'd1);
      chk("rst_we_n", 32'(we_n1), 32'd1);
      chk("rst_stallreq", 32'(stallreq1), 32'd0);
      chk("rst_id_pc", id_pc1, 32'd0);
      chk("rst_id_inst", id_inst1, 32'd0);
      rst = 1'b0;
      fetch(32'h80000000, 32'h3C011234, 6'b000000, 0);
      fetch(32'h80000004, 32'h24210001, 6'b000000, 0);
      fetch(32'h80000008, 32'h8C220000, 6'b000000, 0);
      fetch(32'h8000000C, 32'h00851020, 6'b000111, 3);
      fetch(32'h80000010, 32'hAAAA5555, 6'b000011, 3);
      pc_i = 32'h80000014; ce_i = 1'b1; stall_i = '0;
      tick;
      chk("flush_oe_n_read", 32'(oe_n1), 32'd0);
      tick;
      flush_i = 1'b1;
      pc_i    = 32'h80000180;
      tick;
      chk("flush_oe_n", 32'(oe_n1), 32'd1);
      chk("flush_ce_n", 32'(ce_n1), 32'd1);
      chk("flush_id_pc", id_pc1, 32'd0);
      chk("flush_id_inst", id_inst1, 32'd0);
      chk("flush_stallreq", 32'(stallreq1), 32'd1);
      flush_i   = 1'b0;
      prev_pc   = '0;
      prev_inst = '0;
      fetch(32'h80000180, 32'h3C1FBFC0, 6'b000000, 0);
      pc_i = 32'h80000014; ce_i = 1'b1;
      tick;
      chk("mid_read_oe_n", 32'(oe_n1), 32'd0);
      rst  = 1'b1;
      ce_i = 1'b0;
      tick;
      chk("mid_rst_addr", 32'(addr1), 32'd0);
      chk("mid_rst_ce_n", 32'(ce_n1), 32'd1);
      chk("mid_rst_oe_n", 32'(oe_n1), 32'd1);
      chk("mid_rst_stallreq", 32'(stallreq1), 32'd0);
      chk("mid_rst_id_pc", id_pc1, 32'd0);
      chk("mid_rst_id_inst", id_inst1, 32'd0);
      chk("mid_rst_w1_oe_n", 32'(oe_n2), 32'd1);
      rst  = 1'b0;
      pc_i = 32'h80000000;
      ce_i = 1'b1;
      sb.push_back({32'h80000000, 32'h3C011234});
      #1;
      chk("w1_stallreq_idle", 32'(stallreq2), 32'd1);
      tick;
      chk("w1_stallreq_read", 32'(stallreq2), 32'd1);
      chk("w1_oe_n_read", 32'(oe_n2), 32'd0);
      tick;
      chk("w1_stallreq_done", 32'(stallreq2), 32'd0);
      chk("w1_oe_n_done", 32'(oe_n2), 32'd1);
      tick;
      chk("w1_id_pc", id_pc2, 32'h80000000);
      chk("w1_id_inst", id_inst2, 32'h3C011234);
      tick;
      chk("w1_id_bubble", id_inst2, 32'd0);
      ce_i = 1'b0;
      tick;
      tick;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
